// File: rtl/wor_bus_collector_if.sv
// Signal bundle between the wired-OR agents/consumer and wor_bus_collector.
// The collector uses the slave modport. `WOR_PARITY_EN adds out_par.
interface wor_bus_collector_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int SW = $clog2(N);

   logic [N-1:0]  req;
   logic [W-1:0]  bus;
   logic [N-1:0]  gnt;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_src;
   logic          out_valid;
   logic          out_ready;
`ifdef WOR_PARITY_EN
   logic          out_par;

   modport master (output req, bus, out_ready,
                   input  gnt, out_data, out_src, out_valid, out_par);
   modport slave  (input  req, bus, out_ready,
                   output gnt, out_data, out_src, out_valid, out_par);
`else
   modport master (output req, bus, out_ready,
                   input  gnt, out_data, out_src, out_valid);
   modport slave  (input  req, bus, out_ready,
                   output gnt, out_data, out_src, out_valid);
`endif
endinterface

// File: rtl/wor_bus_collector.sv
// Round-robin grant of a shared wired-OR bus; captures {source, bus} into a small FIFO
// drained by valid/ready. Optional feature: `WOR_PARITY_EN adds registered out_par.
module wor_bus_collector #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   wor_bus_collector_if.slave   bif
);
   localparam int SW = $clog2(N);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   typedef struct packed {
      logic [SW-1:0] src;
      logic [W-1:0]  data;
   } entry_t;

   state_t        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [SW-1:0] idx_q, idx_d;
   logic [SW-1:0] rr_q, rr_d;
   logic          push;

   logic [SW-1:0] pick;
   logic          found;

   logic [PW-1:0] wr_q, rd_q, rd_next;
   logic [CW-1:0] count_q, count_next;
   logic          valid_q, pop, full, load_head;
   entry_t        mem [DEPTH];
   entry_t        new_entry, head_q, head_next;

   // First requester at or after the rr pointer, wrapping N-1 -> 0.
   always_comb begin
      int unsigned   k;
      logic [SW-1:0] cand;
      // NOTE: every variable written here gets a default first so no latch is inferred.
      pick  = '0;
      found = 1'b0;
      k     = 0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         k    = (int'(rr_q) + i) % N;
         cand = SW'(k);
         if (!found && bif.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign full = (count_q == CW'(DEPTH));

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      rr_d    = rr_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (found && !full) begin
               state_d = GRANT;
               gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick;
               idx_d   = pick;
            end
         end
         GRANT: begin
            // Capture happens even if req dropped; the granted agent owns this cycle.
            push    = 1'b1;
            gnt_d   = '0;
            rr_d    = (int'(idx_q) == N - 1) ? '0 : idx_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
      end
   end

   assign new_entry  = '{src: idx_q, data: bif.bus};
   assign pop        = valid_q && bif.out_ready;
   assign rd_next    = pop ? rd_q + 1'b1 : rd_q;
   assign count_next = count_q + CW'(push) - CW'(pop);
   // Head registers reload only when the head entry changes, so they hold when empty.
   assign load_head  = (count_next != '0) && (pop || count_q == '0);
   assign head_next  = (push && rd_next == wr_q) ? new_entry : mem[rd_next];

   // NOTE: storage array is not reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= new_entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         head_q  <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         rd_q    <= rd_next;
         count_q <= count_next;
         valid_q <= (count_next != '0);
         if (load_head) head_q <= head_next;
      end
   end

`ifdef WOR_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            par_q <= 1'b0;
      else if (load_head) par_q <= ^head_next.data;
   end

   assign bif.out_par = par_q;
`endif

   assign bif.gnt       = gnt_q;
   assign bif.out_valid = valid_q;
   assign bif.out_data  = head_q.data;
   assign bif.out_src   = head_q.src;

endmodule

// File: tb/tb_wor_bus_collector.sv
// Self-checking bench for wor_bus_collector: directed table, corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_wor_bus_collector;
   localparam int N     = 4;
   localparam int W     = 8;
   localparam int DEPTH = 2;
   localparam int SW    = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wor_bus_collector_if #(.N(N), .W(W)) bif ();

   wor_bus_collector #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bif (bif)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0] drive_val [N];
   logic [W-1:0] extra;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Wired-OR resolution: granted agent plus any out-of-turn driver.
   function automatic logic [W-1:0] resolve();
      logic [W-1:0] r;
      r = extra;
      for (int i = 0; i < N; i++) if (bif.gnt[i]) r |= drive_val[i];
      return r;
   endfunction

   // Reference model: a capture queue, rr pointer and the agent currently granted.
   typedef struct { int src; int data; } cap_t;
   cap_t m_q[$];
   int   m_rr, m_granted, m_last_src, m_last_data;

   task automatic model_reset();
      m_q.delete();
      m_rr        = 0;
      m_granted   = -1;
      m_last_src  = 0;
      m_last_data = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic rdy, input logic [W-1:0] b);
      int size0;
      size0 = m_q.size();
      if (size0 > 0 && rdy) void'(m_q.pop_front());
      if (m_granted >= 0) begin
         m_q.push_back('{m_granted, int'(b)});
         m_rr      = (m_granted + 1) % N;
         m_granted = -1;
      end else if (r != 0 && size0 < DEPTH) begin
         for (int i = 0; i < N; i++) begin
            int a;
            a = (m_rr + i) % N;
            if (r[a]) begin
               m_granted = a;
               break;
            end
         end
      end
      if (m_q.size() > 0) begin
         m_last_src  = m_q[0].src;
         m_last_data = m_q[0].data;
      end
   endtask

   task automatic cycle();
      logic [N-1:0] r;
      logic         rdy;
      logic [W-1:0] b;
      logic [N-1:0] exp_gnt;
      bif.bus = resolve();
      r   = bif.req;
      rdy = bif.out_ready;
      b   = bif.bus;
      @(posedge clk);
      #1;
      model_step(r, rdy, b);
      exp_gnt = (m_granted >= 0) ? N'(1 << m_granted) : '0;
      check("model_gnt",   32'(bif.gnt),       32'(exp_gnt));
      check("model_valid", 32'(bif.out_valid), 32'(m_q.size() > 0));
      check("model_data",  32'(bif.out_data),  m_last_data);
      check("model_src",   32'(bif.out_src),   m_last_src);
      check("fifo_bound",  32'(m_q.size() <= DEPTH), 32'd1);
      bif.bus = resolve();
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bif.req       = '0;
      bif.out_ready = 1'b0;
      extra         = '0;
      bif.bus       = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_gnt",   32'(bif.gnt),       32'd0);
      check("rst_valid", 32'(bif.out_valid), 32'd0);
      check("rst_data",  32'(bif.out_data),  32'd0);
      check("rst_src",   32'(bif.out_src),   32'd0);
   endtask

   typedef struct {
      logic [N-1:0]  req;
      logic          rdy;
      logic [N-1:0]  gnt;
      logic          valid;
      logic [W-1:0]  data;
      logic [SW-1:0] src;
   } vec_t;

   vec_t tbl [10];
   int   ng;

   initial begin
      // All four requesting, consumer always ready; agent i drives 8'h10+i.
      tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
      tbl[1] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0};
      tbl[2] = '{4'b1111, 1'b1, 4'b0010, 1'b0, 8'h10, 2'd0};
      tbl[3] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd1};
      tbl[4] = '{4'b1111, 1'b1, 4'b0100, 1'b0, 8'h11, 2'd1};
      tbl[5] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'h12, 2'd2};
      tbl[6] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 8'h12, 2'd2};
      tbl[7] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'h13, 2'd3};
      tbl[8] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 8'h13, 2'd3};
      tbl[9] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0};

      for (int i = 0; i < N; i++) drive_val[i] = 8'h10 + 8'(i);
      extra = '0;
      do_reset();

      for (int v = 0; v < 10; v++) begin
         bif.req       = tbl[v].req;
         bif.out_ready = tbl[v].rdy;
         cycle();
         check($sformatf("tbl%0d_gnt", v),   32'(bif.gnt),       32'(tbl[v].gnt));
         check($sformatf("tbl%0d_valid", v), 32'(bif.out_valid), 32'(tbl[v].valid));
         check($sformatf("tbl%0d_data", v),  32'(bif.out_data),  32'(tbl[v].data));
         check($sformatf("tbl%0d_src", v),   32'(bif.out_src),   32'(tbl[v].src));
      end

      // Async reset in the middle of agent 1's grant; first grant afterwards is agent 0.
      cycle();
      check("pre_rst_gnt", 32'(bif.gnt), 32'b0010);
      #2 rst = 1'b1;
      #1;
      check("async_rst_gnt",   32'(bif.gnt),       32'd0);
      check("async_rst_valid", 32'(bif.out_valid), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      cycle();
      check("post_rst_first_gnt", 32'(bif.gnt), 32'b0001);

      // Single requester agent 2 drives 8'hA5.
      do_reset();
      drive_val[2]  = 8'hA5;
      bif.req       = 4'b0100;
      bif.out_ready = 1'b1;
      cycle();
      check("a5_gnt", 32'(bif.gnt), 32'b0100);
      bif.req = '0;
      cycle();
      check("a5_gnt_drop", 32'(bif.gnt),       32'd0);
      check("a5_valid",    32'(bif.out_valid), 32'd1);
      check("a5_data",     32'(bif.out_data),  32'hA5);
      check("a5_src",      32'(bif.out_src),   32'd2);

      // Agent 3 drives out of turn during agent 1's grant; values OR together.
      do_reset();
      drive_val[1]  = 8'h0F;
      bif.req       = 4'b0010;
      bif.out_ready = 1'b1;
      cycle();
      check("wor_gnt", 32'(bif.gnt), 32'b0010);
      extra   = 8'hF0;
      bif.req = '0;
      cycle();
      extra = '0;
      check("wor_data", 32'(bif.out_data), 32'hFF);
      check("wor_src",  32'(bif.out_src),  32'd1);

      // Consumer stalled: exactly DEPTH captures, then one pop frees one slot.
      do_reset();
      bif.req       = 4'b0001;
      bif.out_ready = 1'b0;
      ng = 0;
      repeat (8) begin
         cycle();
         if (bif.gnt != '0) ng++;
      end
      check("full_captures", ng, DEPTH);
      check("full_valid", 32'(bif.out_valid), 32'd1);
      bif.out_ready = 1'b1;
      cycle();
      check("no_gnt_on_pop_edge", 32'(bif.gnt), 32'd0);
      bif.out_ready = 1'b0;
      ng = 0;
      repeat (6) begin
         cycle();
         if (bif.gnt != '0) ng++;
      end
      check("grants_after_pop", ng, 1);

`ifdef WOR_PARITY_EN
      do_reset();
      bif.out_ready = 1'b1;
      drive_val[0]  = 8'h07;
      bif.req       = 4'b0001;
      cycle();
      bif.req = '0;
      cycle();
      check("par_07", 32'(bif.out_par), 32'd1);
      drive_val[0] = 8'h03;
      bif.req      = 4'b0001;
      cycle();
      bif.req = '0;
      cycle();
      check("par_03", 32'(bif.out_par), 32'd0);
`endif

      // Randomized traffic against the reference model, with occasional resets.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         bif.req       = N'($urandom);
         bif.out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) drive_val[i] = W'($urandom);
         extra = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
